// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU: select codes (common with ALU control)
// and the controller state encoding.
package alu_exec_pkg;

    localparam logic [3:0] SEL_ADD = 4'd0;
    localparam logic [3:0] SEL_SUB = 4'd1;
    localparam logic [3:0] SEL_MUL = 4'd2;
    localparam logic [3:0] SEL_SLT = 4'd3;
    localparam logic [3:0] SEL_SLL = 4'd4;
    localparam logic [3:0] SEL_XOR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// The product is presented combinationally alongside o_done so the caller can register it.
module alu_exec_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // The last iteration's sum is handed out directly, saving a cycle of latency.
    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == '0);
    assign o_product = w_acc_next;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes and registered result/zero/illegal.
// Define ALU_EXEC_FAST_MUL_EN for a single-cycle combinational multiply instead of shift-add.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    logic [WIDTH-1:0] w_result;
    logic             w_illegal;
    logic             w_lt;
    logic             w_go_mul;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        w_lt      = $signed(a) < $signed(b);
        case (sel)
            SEL_ADD: w_result = a + b;
            SEL_SUB: w_result = a - b;
            SEL_SLT: w_result = {{(WIDTH-1){1'b0}}, w_lt};
            SEL_SLL: w_result = a << b[SH_W-1:0];
            SEL_XOR: w_result = a ^ b;
`ifdef ALU_EXEC_FAST_MUL_EN
            SEL_MUL: w_result = a * b;
`else
            SEL_MUL: w_result = '0;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_FAST_MUL_EN
    assign w_go_mul = 1'b0;
`else
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    assign w_go_mul    = (sel == SEL_MUL);
    assign w_mul_start = (r_state == ST_IDLE) && in_valid && w_go_mul;

    alu_exec_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_go_mul) begin
                            r_state <= ST_MUL;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_result;
                            r_zero      <= (w_result == '0);
                            r_illegal   <= w_illegal;
                        end
                    end
                end
`ifndef ALU_EXEC_FAST_MUL_EN
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mul_product;
                        r_zero      <= (w_mul_product == '0);
                        r_illegal   <= 1'b0;
                    end else if (!w_mul_busy) begin
                        // Multiplier idle without finishing: recover rather than hang.
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec: hand-computed results, latencies and handshake behaviour.
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam int WIDTH = 32;
`ifdef ALU_EXEC_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = WIDTH + 1;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    int n_total = 0;
    int n_pass  = 0;
    int lat;
    bit busy_ready_seen;
    bit hold_ok;
    bit stale;

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle, then wait (bounded) for out_valid.
    // lat counts cycles from the request cycle to the first cycle showing out_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic rdy, output int n_lat, output bit ready_seen);
        in_valid  = 1'b1;
        sel       = op;
        a         = op_a;
        b         = op_b;
        out_ready = rdy;
        ready_seen = 1'b0;
        step();
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0BAD_F00D;
        n_lat    = 1;
        while (!out_valid && n_lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            step();
            n_lat++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 4'd0;
        a         = '0;
        b         = '0;
        step();
        step();
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    result,             32'd0);
        check("rst_zero",      {31'd0, zero},      32'd0);
        check("rst_illegal",   {31'd0, illegal},   32'd0);
        reset = 1'b0;

        // add with wrap
        run_op(SEL_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, lat, busy_ready_seen);
        check("add_lat",    lat,                32'd1);
        check("add_result", result,             32'd0);
        check("add_zero",   {31'd0, zero},      32'd1);
        check("add_illegal",{31'd0, illegal},   32'd0);
        step();
        check("add_hs_valid", {31'd0, out_valid}, 32'd0);
        check("add_hs_ready", {31'd0, in_ready},  32'd1);

        // slt signed, then sll using only the low shift bits
        run_op(SEL_SLT, 32'hFFFF_FFFE, 32'd1, 1'b1, lat, busy_ready_seen);
        check("slt_result", result,        32'd1);
        check("slt_zero",   {31'd0, zero}, 32'd0);
        step();
        run_op(SEL_SLT, 32'd1, 32'hFFFF_FFFE, 1'b1, lat, busy_ready_seen);
        check("slt_false",  result,        32'd0);
        step();
        run_op(SEL_SLL, 32'd1, 32'h0000_0023, 1'b1, lat, busy_ready_seen);
        check("sll_result", result,        32'd8);
        step();

        // sub wrap and xor
        run_op(SEL_SUB, 32'd3, 32'd5, 1'b1, lat, busy_ready_seen);
        check("sub_result", result, 32'hFFFF_FFFE);
        step();
        run_op(SEL_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, lat, busy_ready_seen);
        check("xor_result", result, 32'h0FF0_0FF0);
        step();

        // multiply: signed-looking operand, truncation to zero, plain shift
        run_op(SEL_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, lat, busy_ready_seen);
        check("mul_lat",         lat,                       MUL_LAT);
        check("mul_result",      result,                    32'hFFFF_FFEB);
        check("mul_ready_low",   {31'd0, busy_ready_seen},  32'd0);
        check("mul_illegal",     {31'd0, illegal},          32'd0);
        step();
        run_op(SEL_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, lat, busy_ready_seen);
        check("mul_trunc_result", result,        32'd0);
        check("mul_trunc_zero",   {31'd0, zero}, 32'd1);
        step();
        run_op(SEL_MUL, 32'h1234_5678, 32'h0000_0010, 1'b1, lat, busy_ready_seen);
        check("mul_shift_result", result, 32'h2345_6780);
        step();

        // back-pressure: hold in DONE, ignore in_valid pulses
        run_op(SEL_SUB, 32'd5, 32'd5, 1'b0, lat, busy_ready_seen);
        check("bp_lat",    lat,           32'd1);
        check("bp_result", result,        32'd0);
        check("bp_zero",   {31'd0, zero}, 32'd1);
        hold_ok = 1'b1;
        sel = SEL_ADD;
        a   = 32'd1;
        b   = 32'd1;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            step();
            if (!(out_valid && result == 32'd0 && zero && !in_ready)) hold_ok = 1'b0;
        end
        check("bp_hold", {31'd0, hold_ok}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready},  32'd1);
        step();
        check("bp_no_extra", {31'd0, out_valid}, 32'd0);

        // illegal selects, then a legal op clears the flag
        run_op(4'd9, 32'd12, 32'd34, 1'b1, lat, busy_ready_seen);
        check("ill9_lat",     lat,               32'd1);
        check("ill9_result",  result,            32'd0);
        check("ill9_illegal", {31'd0, illegal},  32'd1);
        check("ill9_zero",    {31'd0, zero},     32'd1);
        step();
        run_op(4'd5, 32'd1, 32'd1, 1'b1, lat, busy_ready_seen);
        check("ill5_illegal", {31'd0, illegal},  32'd1);
        step();
        run_op(4'hF, 32'd1, 32'd1, 1'b1, lat, busy_ready_seen);
        check("illF_illegal", {31'd0, illegal},  32'd1);
        step();
        run_op(SEL_ADD, 32'd2, 32'd3, 1'b1, lat, busy_ready_seen);
        check("post_ill_result",  result,           32'd5);
        check("post_ill_illegal", {31'd0, illegal}, 32'd0);
        step();

        // reset ten cycles into a multiply discards it
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = SEL_MUL;
        a         = 32'd3;
        b         = 32'd5;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        check("rmul_valid",  {31'd0, out_valid}, 32'd0);
        check("rmul_ready",  {31'd0, in_ready},  32'd1);
        check("rmul_result", result,             32'd0);
        reset = 1'b0;
        stale = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) stale = 1'b1;
        end
        check("rmul_no_stale", {31'd0, stale}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
